mem_responder: RTL
==================

Name: mem_responder

Overview:
Memory-side endpoint of the cache/memory bus: a behavioural main-memory controller that accepts single-beat write packets and block-read requests forwarded by the bus arbiter. It returns read data as a burst of block_size_p/dma_data_width_p beats after a fixed access latency. Used as the memory model in single- and multi-core simulation, and as the template for a later real memory controller.

Parameters:
block_size_p, 8, words per cache block; must be a multiple of dma_data_width_p.
dma_data_width_p, 2, words per bus beat; beat width is dma_data_width_p*32 bits.
mem_words_p, 1024, 32-bit words of storage; power of two.
latency_p, 4, cycles from read acceptance to the first data beat; must be >= 1.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
mem_valid_i  in  1  request valid from the bus.
mem_ready_o  out  1  responder can accept a request this cycle.
mem_we_i  in  1  1 = write beat, 0 = block read.
mem_addr_i  in  32  byte address.
mem_wdata_i  in  dma_data_width_p*32  write beat data.
mem_valid_o  out  1  read data beat valid.
mem_data_o  out  dma_data_width_p*32  read data beat.

Behaviour:
- Constants: N = block_size_p/dma_data_width_p beats per block; word index = mem_addr_i[2 +: log2(mem_words_p)]. Upper address bits are ignored (index wraps modulo mem_words_p).
- Beat packing: word j of a beat occupies bits [32j +: 32]; the lowest address goes in the lowest bits.
- Handshake: a request is accepted in a cycle where mem_valid_i & mem_ready_o. mem_ready_o is a registered state decode, with no combinational path from mem_valid_i.
- FSM states are IDLE, WAIT and BURST.
  - IDLE: mem_ready_o=1, mem_valid_o=0.
  - Accepted write: the beat is stored at word index rounded down to a beat boundary (low log2(dma_data_width_p) index bits forced 0). Storage updates at the accepting edge. State stays IDLE, so back-to-back writes are accepted every cycle.
  - Accepted read: latch base = word index with the low log2(block_size_p) bits forced 0. Go to WAIT with the latency counter loaded to latency_p-1; if latency_p==1, go directly to BURST.
  - WAIT: mem_ready_o=0, mem_valid_o=0. The counter decrements each cycle; at 0, go to BURST with beat counter=0.
  - BURST: mem_ready_o=0, mem_valid_o=1. mem_data_o = words base+k*dma_data_width_p ... +dma_data_width_p-1 for beat k. Beats advance every cycle; there is no backpressure, so the consumer must always sink.
  - After beat N-1, return to IDLE.
- Timing: with the acceptance cycle numbered 0, beats are valid in cycles latency_p .. latency_p+N-1, and mem_ready_o=1 again in cycle latency_p+N.
- Read data comes from storage at beat time. A write accepted in cycle t is visible to a read accepted in cycle t+1.
- mem_data_o is don't-care when mem_valid_o=0, but is driven to 0 in IDLE and WAIT for clean waveforms.
- mem_valid_i while mem_ready_o=0 is ignored; the bus holds the request until accepted.
- Reset: while reset_i=1, FSM=IDLE, counters=0, mem_ready_o=1, mem_valid_o=0, mem_data_o=0. Reset mid-WAIT or mid-BURST aborts the burst with no further beats. The storage array is not reset and its contents are retained.
- Simulation assertions: N >= 1; block_size_p % dma_data_width_p == 0; latency_p >= 1; mem_valid_o never high in IDLE or WAIT.

Test Plan:
- Write then read: write beats {0x11,0x22}@0x00, {0x33,0x44}@0x08, {0x55,0x66}@0x10, {0x77,0x88}@0x18, back-to-back, then read @0x04 -> mem_ready_o stays 1 during the writes. Beats {0x11,0x22},{0x33,0x44},{0x55,0x66},{0x77,0x88} appear in cycles 4–7 after read acceptance; ready returns in cycle 8.
- Latency edge: latency_p=1, read @0x20 -> first beat in cycle 1 after acceptance, 4 consecutive beats, no WAIT cycle.
- Backpressure ignore: hold mem_valid_i=1 with a write to 0x40 during a read burst -> the write is not accepted until IDLE, then stored exactly once; a readback returns the written data.
- Wrap: mem_words_p=1024, write @0x1000 then read @0x0000 -> data from 0x1000 appears at index 0.
- Reset mid-burst: assert reset_i asynchronously after beat 1 -> mem_valid_o=0 immediately, ready=1. A re-read of the same block returns the unchanged contents.
- Read-after-write: write in cycle t, read the same block accepted in cycle t+1 -> the new data is returned.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the bus arbiter and the memory responder.
// The master drives requests and write data; the slave returns ready and read beats.
interface mem_responder_if #(
    parameter int dma_data_width_p = 2
);
    logic                            mem_valid_i;
    logic                            mem_ready_o;
    logic                            mem_we_i;
    logic [31:0]                     mem_addr_i;
    logic [dma_data_width_p*32-1:0]  mem_wdata_i;
    logic                            mem_valid_o;
    logic [dma_data_width_p*32-1:0]  mem_data_o;

    modport master (
        output mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  mem_ready_o, mem_valid_o, mem_data_o
    );

    modport slave (
        input  mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output mem_ready_o, mem_valid_o, mem_data_o
    );
endinterface

// File: rtl/mem_responder.sv
// Behavioural main-memory endpoint: single-beat writes, block reads returned as a
// fixed-latency burst of block_size_p/dma_data_width_p beats with no backpressure.
module mem_responder #(
    parameter int block_size_p     = 8,
    parameter int dma_data_width_p = 2,
    parameter int mem_words_p      = 1024,
    parameter int latency_p        = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    mem_responder_if.slave     bus
);
    localparam int N          = block_size_p / dma_data_width_p;
    localparam int BEAT_W     = dma_data_width_p * 32;
    localparam int IDX_W      = $clog2(mem_words_p);
    localparam int BEAT_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LAT_CNT_W  = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [IDX_W-1:0]      BEAT_MASK = {IDX_W{1'b1}} << $clog2(dma_data_width_p);
    localparam logic [IDX_W-1:0]      BLOCK_MASK = {IDX_W{1'b1}} << $clog2(block_size_p);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t                state_q;
    logic [LAT_CNT_W-1:0]  latCnt_q;
    logic [BEAT_CNT_W-1:0] beatCnt_q;
    logic [IDX_W-1:0]      base_q;
    logic                  ready_q;
    logic                  valid_q;
    logic [BEAT_W-1:0]     data_q;

    logic [31:0]           mem_q [mem_words_p];

    logic [IDX_W-1:0]      wordIdx;
    logic [IDX_W-1:0]      readBase;
    logic [IDX_W-1:0]      writeIdx;
    logic [IDX_W-1:0]      fetchIdx_d;
    logic [BEAT_W-1:0]     fetchBeat_d;
    logic                  wrEn;
    logic                  unusedAddrBits;

    assign wordIdx        = bus.mem_addr_i[2 +: IDX_W];
    assign readBase       = wordIdx & BLOCK_MASK;
    assign writeIdx       = wordIdx & BEAT_MASK;
    assign unusedAddrBits = ^{bus.mem_addr_i[31:IDX_W+2], bus.mem_addr_i[1:0]};

    // Writes are only taken while idle, so storage never changes under a burst in flight.
    assign wrEn = ~reset_i & (state_q == IDLE) & bus.mem_valid_i & bus.mem_we_i;

    // Index of the beat that will be presented next cycle.
    always_comb begin
        fetchIdx_d = base_q;
        if (state_q == IDLE) begin
            fetchIdx_d = readBase;
        end else if (state_q == BURST) begin
            fetchIdx_d = base_q + IDX_W'((32'(beatCnt_q) + 32'd1) * dma_data_width_p);
        end
    end

    always_comb begin
        fetchBeat_d = '0;
        for (int j = 0; j < dma_data_width_p; j++) begin
            fetchBeat_d[32*j +: 32] = mem_q[fetchIdx_d + IDX_W'(j)];
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            for (int j = 0; j < dma_data_width_p; j++) begin
                mem_q[writeIdx + IDX_W'(j)] <= bus.mem_wdata_i[32*j +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            latCnt_q  <= '0;
            beatCnt_q <= '0;
            base_q    <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_valid_i && !bus.mem_we_i) begin
                        base_q  <= readBase;
                        ready_q <= 1'b0;
                        if (latency_p == 1) begin
                            state_q   <= BURST;
                            beatCnt_q <= '0;
                            valid_q   <= 1'b1;
                            data_q    <= fetchBeat_d;
                        end else begin
                            state_q  <= WAIT;
                            latCnt_q <= LAT_CNT_W'(latency_p - 1);
                        end
                    end
                end
                WAIT: begin
                    latCnt_q <= latCnt_q - LAT_CNT_W'(1);
                    // Leaving on the 1->0 step puts beat 0 exactly latency_p cycles after acceptance.
                    if (latCnt_q == LAT_CNT_W'(1)) begin
                        state_q   <= BURST;
                        beatCnt_q <= '0;
                        valid_q   <= 1'b1;
                        data_q    <= fetchBeat_d;
                    end
                end
                BURST: begin
                    if (beatCnt_q == LAST_BEAT) begin
                        state_q   <= IDLE;
                        beatCnt_q <= '0;
                        ready_q   <= 1'b1;
                        valid_q   <= 1'b0;
                        data_q    <= '0;
                    end else begin
                        beatCnt_q <= beatCnt_q + BEAT_CNT_W'(1);
                        data_q    <= fetchBeat_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign bus.mem_ready_o = ready_q;
    assign bus.mem_valid_o = valid_q;
    assign bus.mem_data_o  = data_q;

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (N >= 1);
            assert (block_size_p % dma_data_width_p == 0);
            assert (latency_p >= 1);
            assert (!(valid_q && state_q != BURST));
        end
    end
endmodule
